// File: rtl/tcam_ctrl_if.sv
// Request/response and parallel-memory bus of the TCAM controller.
interface tcam_ctrl_if #(
   parameter int WIDTH      = 32,
   parameter int SIZE       = 32,
   parameter int INDEX_SIZE = 5
);
   logic                  write_go;
   logic [INDEX_SIZE-1:0] write_index;
   logic [WIDTH-1:0]      write_data;
   logic                  write_valid;
   logic                  write_done;
   logic                  search_go;
   logic [WIDTH-1:0]      search_key;
   logic                  search_done;
   logic                  search_found;
   logic [INDEX_SIZE-1:0] search_index;
   logic [INDEX_SIZE-1:0] mem_index;
   logic [WIDTH-1:0]      mem_write_data;
   logic                  mem_write_en;
   logic                  mem_done;
   logic [SIZE*WIDTH-1:0] mem_read;

   // Requester and memory side
   modport master (
      output write_go, write_index, write_data, write_valid,
      input  write_done,
      output search_go, search_key,
      input  search_done, search_found, search_index,
      input  mem_index, mem_write_data, mem_write_en,
      output mem_done, mem_read
   );

   // Controller side
   modport slave (
      input  write_go, write_index, write_data, write_valid,
      output write_done,
      input  search_go, search_key,
      output search_done, search_found, search_index,
      output mem_index, mem_write_data, mem_write_en,
      input  mem_done, mem_read
   );
endinterface

// File: rtl/tcam_ctrl.sv
// TCAM controller: arbitrates write/search requests, writes entries through a
// single memory write port, and scans 4 entries per cycle on search.
module tcam_ctrl #(
   parameter int WIDTH      = 32,
   parameter int SIZE       = 32,
   parameter int INDEX_SIZE = 5
) (
   input logic         clk,
   input logic         reset,
   tcam_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, WR, WR_WAIT, SRCH, FIN} state_e;
   typedef enum logic {GNT_WR, GNT_SRCH} grant_e;

   localparam logic [INDEX_SIZE-1:0] LAST_PTR = INDEX_SIZE'(SIZE - 4);
   localparam logic [INDEX_SIZE-1:0] PTR_STEP = INDEX_SIZE'(4);

   state_e                state_q, state_d;
   grant_e                last_grant_q, last_grant_d;
   logic [SIZE-1:0]       valid_q, valid_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [INDEX_SIZE-1:0] mem_index_q, mem_index_d;
   logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0]      key_q, key_d;
   logic [INDEX_SIZE-1:0] ptr_q, ptr_d;
   logic                  found_q, found_d;
   logic [INDEX_SIZE-1:0] index_q, index_d;

   logic                  hit;
   logic [INDEX_SIZE-1:0] hit_idx;
   logic [INDEX_SIZE-1:0] idx;
   logic                  grant_wr;
   logic                  grant_sr;
   logic                  mem_write_en;
   logic                  write_done;
   logic                  search_done;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_SRCH;
         valid_q      <= '0;
         pend_valid_q <= 1'b0;
         mem_index_q  <= '0;
         mem_wdata_q  <= '0;
         key_q        <= '0;
         ptr_q        <= '0;
         found_q      <= 1'b0;
         index_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         valid_q      <= valid_d;
         pend_valid_q <= pend_valid_d;
         mem_index_q  <= mem_index_d;
         mem_wdata_q  <= mem_wdata_d;
         key_q        <= key_d;
         ptr_q        <= ptr_d;
         found_q      <= found_d;
         index_q      <= index_d;
      end
   end

   // Next state: arbitration, write sequencing and the 4-wide search scan
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      valid_d      = valid_q;
      pend_valid_d = pend_valid_q;
      mem_index_d  = mem_index_q;
      mem_wdata_d  = mem_wdata_q;
      key_d        = key_q;
      ptr_d        = ptr_q;
      found_d      = found_q;
      index_d      = index_q;
      hit          = 1'b0;
      hit_idx      = '0;
      idx          = '0;

      // lowest matching valid entry within the current group of four
      for (int unsigned j = 0; j < 4; j++) begin
         idx = ptr_q + INDEX_SIZE'(j);
         if (!hit && valid_q[idx] &&
             (bus.mem_read[int'(idx) * WIDTH +: WIDTH] == key_q)) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end

      // write wins unless search is also requesting and write went last
      grant_wr = bus.write_go && (!bus.search_go || (last_grant_q == GNT_SRCH));
      grant_sr = bus.search_go && !grant_wr;

      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               mem_index_d  = bus.write_index;
               mem_wdata_d  = bus.write_data;
               pend_valid_d = bus.write_valid;
               last_grant_d = GNT_WR;
               state_d      = WR;
            end else if (grant_sr) begin
               key_d        = bus.search_key;
               ptr_d        = '0;
               last_grant_d = GNT_SRCH;
               state_d      = SRCH;
            end
         end
         WR:      state_d = WR_WAIT;
         WR_WAIT: begin
            if (bus.mem_done) begin
               valid_d[mem_index_q] = pend_valid_q;
               state_d              = FIN;
            end
         end
         SRCH: begin
            if (hit) begin
               found_d = 1'b1;
               index_d = hit_idx;
               state_d = FIN;
            end else if (ptr_q == LAST_PTR) begin
               found_d = 1'b0;
               index_d = '0;
               state_d = FIN;
            end else begin
               ptr_d = ptr_q + PTR_STEP;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      mem_write_en = (state_q == WR);
      write_done   = (state_q == FIN) && (last_grant_q == GNT_WR);
      search_done  = (state_q == FIN) && (last_grant_q == GNT_SRCH);
   end

   assign bus.mem_write_en   = mem_write_en;
   assign bus.write_done     = write_done;
   assign bus.search_done    = search_done;
   assign bus.mem_index      = mem_index_q;
   assign bus.mem_write_data = mem_wdata_q;
   assign bus.search_found   = found_q;
   assign bus.search_index   = index_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed testbench for tcam_ctrl with a behavioural parallel memory.
module tb_tcam_ctrl;

   localparam int W  = 32;
   localparam int N  = 32;
   localparam int IW = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   tcam_ctrl_if #(.WIDTH(W), .SIZE(N), .INDEX_SIZE(IW)) bus ();

   tcam_ctrl #(.WIDTH(W), .SIZE(N), .INDEX_SIZE(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // memory: write on mem_write_en, acknowledge the following cycle
   logic [W-1:0] mem [N];
   logic         mem_done_r = 1'b0;
   initial for (int i = 0; i < N; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (bus.mem_write_en) mem[bus.mem_index] <= bus.mem_write_data;
      mem_done_r <= bus.mem_write_en;
   end
   assign bus.mem_done = mem_done_r;
   for (genvar g = 0; g < N; g++) begin : g_rd
      assign bus.mem_read[g*W +: W] = mem[g];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [IW-1:0] idx, input logic [W-1:0] data, input logic v,
                           output int lat, output int we_cnt, output int stray);
      bit done;
      done = 0; lat = 0; we_cnt = 0; stray = 0;
      @(posedge clk); #1;
      bus.write_index = idx; bus.write_data = data; bus.write_valid = v; bus.write_go = 1'b1;
      @(posedge clk);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.mem_write_en) we_cnt++;
         if (bus.search_done) stray++;
         if (bus.write_done) done = 1;
      end
      bus.write_go = 1'b0;
   endtask

   task automatic do_search(input logic [W-1:0] key, output int lat, output int stray);
      bit done;
      done = 0; lat = 0; stray = 0;
      @(posedge clk); #1;
      bus.search_key = key; bus.search_go = 1'b1;
      @(posedge clk);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.write_done) stray++;
         if (bus.search_done) done = 1;
      end
      bus.search_go = 1'b0;
   endtask

   initial begin
      int lat, we, stray, n, sd_cnt;
      logic [3:0] order;

      bus.write_go = 1'b0; bus.write_index = '0; bus.write_data = '0; bus.write_valid = 1'b0;
      bus.search_go = 1'b0; bus.search_key = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_write_done",  bus.write_done, 0);
      check("rst_search_done", bus.search_done, 0);
      check("rst_found",       bus.search_found, 0);
      check("rst_index",       bus.search_index, 0);
      check("rst_mem_we",      bus.mem_write_en, 0);
      check("rst_mem_index",   bus.mem_index, 0);
      check("rst_mem_wdata",   bus.mem_write_data, 0);

      // zero key after reset: memory holds zeros but nothing is valid
      do_search(32'h0, lat, stray);
      check("zero_key_found", bus.search_found, 0);
      check("zero_key_lat",   lat, 9);

      // write idx 5 then find it
      do_write(5'd5, 32'hDEADBEEF, 1'b1, lat, we, stray);
      check("wr5_lat",       lat, 3);
      check("wr5_we_cycles", we, 1);
      check("wr5_mem_index", bus.mem_index, 5);
      check("wr5_mem_wdata", bus.mem_write_data, 32'hDEADBEEF);
      check("wr5_stray_sd",  stray, 0);
      @(negedge clk);
      check("wr5_we_low",    bus.mem_write_en, 0);
      do_search(32'hDEADBEEF, lat, stray);
      check("s5_found", bus.search_found, 1);
      check("s5_index", bus.search_index, 5);
      check("s5_lat",   lat, 3);
      check("s5_stray_wd", stray, 0);

      // duplicates at 9 and 2: lowest index wins; writes leave search result alone
      do_write(5'd9, 32'h12345678, 1'b1, lat, we, stray);
      check("wr9_lat", lat, 3);
      check("hold_found", bus.search_found, 1);
      check("hold_index", bus.search_index, 5);
      do_write(5'd2, 32'h12345678, 1'b1, lat, we, stray);
      do_search(32'h12345678, lat, stray);
      check("dup_found", bus.search_found, 1);
      check("dup_index", bus.search_index, 2);
      check("dup_lat",   lat, 2);

      // absent key
      do_search(32'hCAFEF00D, lat, stray);
      check("miss_found", bus.search_found, 0);
      check("miss_index", bus.search_index, 0);
      check("miss_lat",   lat, 9);

      // invalidate idx 5
      do_write(5'd5, 32'h0, 1'b0, lat, we, stray);
      check("inv5_mem_wdata", bus.mem_write_data, 0);
      do_search(32'hDEADBEEF, lat, stray);
      check("inv5_found", bus.search_found, 0);
      check("inv5_lat",   lat, 9);

      // both requests held together: last grant was search, so W,S,W,S
      @(posedge clk); #1;
      bus.write_index = 5'd7; bus.write_data = 32'hA5A5A5A5; bus.write_valid = 1'b1;
      bus.search_key = 32'h12345678;
      bus.write_go = 1'b1; bus.search_go = 1'b1;
      n = 0; order = '0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         @(negedge clk);
         if (bus.write_done && n < 4) begin order[n] = 1'b0; n++; end
         if (bus.search_done && n < 4) begin order[n] = 1'b1; n++; end
      end
      bus.write_go = 1'b0; bus.search_go = 1'b0;
      check("rr_count", n, 4);
      check("rr_order", order, 4'b1010);
      check("rr_found", bus.search_found, 1);
      check("rr_index", bus.search_index, 2);

      // reset during SRCH aborts the search
      @(posedge clk); #1;
      bus.search_key = 32'hCAFEF00D; bus.search_go = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1; bus.search_go = 1'b0;
      sd_cnt = 0;
      @(negedge clk);
      if (bus.search_done) sd_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      if (bus.search_done) sd_cnt++;
      check("abort_found",     bus.search_found, 0);
      check("abort_index",     bus.search_index, 0);
      check("abort_mem_index", bus.mem_index, 0);
      check("abort_mem_wdata", bus.mem_write_data, 0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.search_done) sd_cnt++;
      end
      check("abort_no_done", sd_cnt, 0);
      do_search(32'hA5A5A5A5, lat, stray);
      check("post_abort_found7", bus.search_found, 0);
      check("post_abort_lat",    lat, 9);
      do_search(32'h12345678, lat, stray);
      check("post_abort_found2", bus.search_found, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tcam_ctrl.md
TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning entry/key width in bits.
REQ-002 SHALL have parameter SIZE, default 32, meaning entry count; only 32 is supported, matching the 32-read parallel memory.
REQ-003 SHALL have parameter INDEX_SIZE, default 5, meaning entry index width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port write_go, input, 1, meaning write request, held high until write_done.
REQ-007 SHALL have port write_index, input, INDEX_SIZE, meaning target entry.
REQ-008 SHALL have port write_data, input, WIDTH, meaning entry value.
REQ-009 SHALL have port write_valid, input, 1, meaning 1 validates the entry and 0 invalidates it.
REQ-010 SHALL have port write_done, output, 1, meaning one-cycle completion pulse.
REQ-011 SHALL have port search_go, input, 1, meaning search request, held high until search_done.
REQ-012 SHALL have port search_key, input, WIDTH, meaning the lookup key.
REQ-013 SHALL have port search_done, output, 1, meaning one-cycle completion pulse.
REQ-014 SHALL have port search_found, output, 1, meaning the last search hit.
REQ-015 SHALL have port search_index, output, INDEX_SIZE, meaning the lowest matching index of the last search.
REQ-016 SHALL have ports mem_index (INDEX_SIZE), mem_write_data (WIDTH) and mem_write_en (1), all outputs, driving the parallel memory write port.
REQ-017 SHALL have port mem_done, input, 1, meaning the memory write acknowledge.
REQ-018 SHALL have port mem_read, input, SIZE*WIDTH, meaning all memory lines concatenated, with entry i at bits [i*WIDTH +: WIDTH].

Function
REQ-019 SHALL implement FSM states IDLE, WR, WR_WAIT, SRCH, FIN.
REQ-020 SHALL keep a SIZE-bit valid bitmap; only valid entries can match.
REQ-021 SHALL, in IDLE, grant at most one request per cycle; if only one go is high, that request SHALL be granted.
REQ-022 SHALL, when both gos are high in IDLE, grant round-robin: the class opposite to last_grant wins; last_grant updates on every grant.
REQ-023 SHALL, on a write grant, register write_index/write_data/write_valid into mem_index/mem_write_data/a pending-valid flag and go to WR.
REQ-024 SHALL, in WR, assert mem_write_en for exactly one cycle, then go to WR_WAIT.
REQ-025 SHALL, in WR_WAIT, wait for mem_done=1, then set valid[mem_index] to the pending-valid flag and go to FIN.
REQ-026 SHALL, on a search grant, latch search_key, clear the scan pointer to 0 and go to SRCH.
REQ-027 SHALL, in SRCH, compare entries ptr..ptr+3 per cycle; an entry matches when it is valid and mem_read entry == key.
REQ-028 SHALL, on any match in SRCH, register search_found=1 and search_index=lowest matching index, then go to FIN (early exit).
REQ-029 SHALL, on no match, advance ptr by 4; when the group at ptr=28 misses, it SHALL register search_found=0, search_index=0 and go to FIN.
REQ-030 SHALL, in FIN, pulse exactly one of write_done or search_done for one cycle, matching the granted class, then return to IDLE.
REQ-031 SHALL give write latency of 3 cycles from the grant edge to write_done, given mem_done arriving the cycle after mem_write_en.
REQ-032 SHALL give search latency of floor(i/4)+2 cycles for a hit at index i, and 9 cycles for a miss.
REQ-033 SHALL hold search_found/search_index stable until the next search reaches FIN.
REQ-034 SHALL keep mem_write_en low in every state except WR; mem_index/mem_write_data hold their last values.
REQ-035 SHALL ignore a go arriving during a non-IDLE state until IDLE.
REQ-036 SHALL perform no memory write while a search is in progress (a single FSM guarantees this).

Reset
REQ-037 SHALL, on reset, set the state to IDLE, the valid bitmap to all zeros, and last_grant to search so that write wins the first tie.
REQ-038 SHALL, on reset, drive all outputs to 0: write_done, search_done, search_found, search_index, mem_write_en, mem_index, mem_write_data.
REQ-039 SHALL, on reset mid-operation, abort immediately with no done pulse and no valid update; memory contents persist but are invalid.

Verification
REQ-040 SHALL cover: write idx 5 data 0xDEADBEEF valid=1 -> mem_write_en one cycle, write_done 3 cycles after grant; then search 0xDEADBEEF -> found=1, index=5, done 3 cycles after grant.
REQ-041 SHALL cover: identical data written at idx 9 and idx 2, search that value -> index=2.
REQ-042 SHALL cover: search an absent key -> found=0, index=0, done 9 cycles after grant; a search after reset with a zero key -> found=0.
REQ-043 SHALL cover: write idx 5 valid=0 after REQ-040 -> search 0xDEADBEEF gives found=0.
REQ-044 SHALL cover: write_go and search_go rising together twice in a row -> grant order write, search, write, search.
REQ-045 SHALL cover: reset asserted in SRCH -> no search_done, outputs 0, a subsequent search finds nothing.
